// File: rtl/mul_share_ctrl_pkg.sv
// Shared definitions for the shared-multiplier controller.
//   - FSM state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   - requester-ID width and type
//   - default operand width and core latency budget
//   - helper that returns the other requester of the pair
package mul_share_ctrl_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_MAX_LAT = 64;

    // Two requesters, so one bit identifies the owner.
    localparam int unsigned REQ_ID_W = 1;

    // Timer width covers the whole legal MAX_LAT range (2..255).
    localparam int unsigned TIMER_W = 8;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // The opposite requester of a two-way pair.
    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/mul_share_ctrl_rr_arb2.sv
// Two-way round-robin grant.
// Picks the single valid requester; when both are valid, picks the one that
// was not served last.
//   valid0_i, valid1_i : requester valids
//   last_grant_i       : requester served most recently
//   gnt_valid_o        : some requester is granted (combinational)
//   gnt_id_o           : granted requester (combinational)
module mul_share_ctrl_rr_arb2
    import mul_share_ctrl_pkg::*;
(
    input  logic    valid0_i,
    input  logic    valid1_i,
    input  req_id_t last_grant_i,
    output logic    gnt_valid_o,
    output req_id_t gnt_id_o
);

    // Grant decision: tie broken away from the last winner.
    always_comb begin
        gnt_valid_o = valid0_i | valid1_i;
        gnt_id_o    = '0;
        if (valid0_i && valid1_i) begin
            gnt_id_o = other_id(last_grant_i);
        end else if (valid1_i) begin
            gnt_id_o = REQ_ID_W'(1);
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one multi-cycle signed multiplier core between two requesters.
// A round-robin arbiter grants one request at a time; the controller latches
// the operands, pulses the core's start, waits for done (bounded by a
// watchdog of MAX_LAT cycles) and returns the 2*WIDTH product, or a zero
// result with err set on timeout, to the requester that issued it.
//   clk_i, reset_ni                     : clock, async active-low reset
//   reqN_valid_i/ready_o/a_i/b_i        : request channel of requester N
//   rspN_valid_o/ready_i/result_o/err_o : response channel of requester N
//   mul_start_o/a_o/b_o                 : start pulse and operands to the core
//   mul_done_i/result_i                 : done pulse and product from the core
//   busy_o                              : controller is not idle
module mul_share_ctrl
    import mul_share_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned MAX_LAT = DEFAULT_MAX_LAT
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,

    input  logic                 req0_valid_i,
    output logic                 req0_ready_o,
    input  logic [WIDTH-1:0]     req0_a_i,
    input  logic [WIDTH-1:0]     req0_b_i,
    output logic                 rsp0_valid_o,
    input  logic                 rsp0_ready_i,
    output logic [2*WIDTH-1:0]   rsp0_result_o,
    output logic                 rsp0_err_o,

    input  logic                 req1_valid_i,
    output logic                 req1_ready_o,
    input  logic [WIDTH-1:0]     req1_a_i,
    input  logic [WIDTH-1:0]     req1_b_i,
    output logic                 rsp1_valid_o,
    input  logic                 rsp1_ready_i,
    output logic [2*WIDTH-1:0]   rsp1_result_o,
    output logic                 rsp1_err_o,

    output logic                 mul_start_o,
    output logic [WIDTH-1:0]     mul_a_o,
    output logic [WIDTH-1:0]     mul_b_o,
    input  logic                 mul_done_i,
    input  logic [2*WIDTH-1:0]   mul_result_i,

    output logic                 busy_o
);

    localparam int unsigned RES_W = 2 * WIDTH;
    localparam logic [TIMER_W-1:0] TIMEOUT_CNT = TIMER_W'(MAX_LAT - 1);

    state_e               state_q,       state_d;
    req_id_t              owner_q,       owner_d;
    req_id_t              last_q,        last_d;
    logic [WIDTH-1:0]     a_q,           a_d;
    logic [WIDTH-1:0]     b_q,           b_d;
    logic [TIMER_W-1:0]   timer_q,       timer_d;
    logic                 start_q,       start_d;
    logic                 busy_q,        busy_d;
    logic                 rsp0_valid_q,  rsp0_valid_d;
    logic [RES_W-1:0]     rsp0_result_q, rsp0_result_d;
    logic                 rsp0_err_q,    rsp0_err_d;
    logic                 rsp1_valid_q,  rsp1_valid_d;
    logic [RES_W-1:0]     rsp1_result_q, rsp1_result_d;
    logic                 rsp1_err_q,    rsp1_err_d;

    logic                 gnt_valid_c;
    req_id_t              gnt_id_c;
    logic                 owner_is1_c;
    logic                 rsp_hs_c;

    mul_share_ctrl_rr_arb2 u_arb (
        .valid0_i     (req0_valid_i),
        .valid1_i     (req1_valid_i),
        .last_grant_i (last_q),
        .gnt_valid_o  (gnt_valid_c),
        .gnt_id_o     (gnt_id_c)
    );

    // Ready is only offered while idle, and only to the granted requester.
    assign req0_ready_o = (state_q == ST_IDLE) && gnt_valid_c && (gnt_id_c == REQ_ID_W'(0));
    assign req1_ready_o = (state_q == ST_IDLE) && gnt_valid_c && (gnt_id_c == REQ_ID_W'(1));

    assign owner_is1_c = (owner_q == REQ_ID_W'(1));
    assign rsp_hs_c    = owner_is1_c ? (rsp1_valid_q && rsp1_ready_i)
                                     : (rsp0_valid_q && rsp0_ready_i);

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        a_d           = a_q;
        b_d           = b_q;
        timer_d       = timer_q;
        start_d       = 1'b0;
        rsp0_valid_d  = rsp0_valid_q;
        rsp0_result_d = rsp0_result_q;
        rsp0_err_d    = rsp0_err_q;
        rsp1_valid_d  = rsp1_valid_q;
        rsp1_result_d = rsp1_result_q;
        rsp1_err_d    = rsp1_err_q;

        unique case (state_q)
            ST_IDLE: begin
                // A grant implies the granted requester is valid: handshake.
                if (gnt_valid_c) begin
                    owner_d = gnt_id_c;
                    a_d     = (gnt_id_c == REQ_ID_W'(1)) ? req1_a_i : req0_a_i;
                    b_d     = (gnt_id_c == REQ_ID_W'(1)) ? req1_b_i : req0_b_i;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Done wins over a timeout falling in the same cycle.
                if (mul_done_i) begin
                    if (owner_is1_c) begin
                        rsp1_valid_d  = 1'b1;
                        rsp1_result_d = mul_result_i;
                        rsp1_err_d    = 1'b0;
                    end else begin
                        rsp0_valid_d  = 1'b1;
                        rsp0_result_d = mul_result_i;
                        rsp0_err_d    = 1'b0;
                    end
                    state_d = ST_RESP;
                end else if (timer_q == TIMEOUT_CNT) begin
                    if (owner_is1_c) begin
                        rsp1_valid_d  = 1'b1;
                        rsp1_result_d = '0;
                        rsp1_err_d    = 1'b1;
                    end else begin
                        rsp0_valid_d  = 1'b1;
                        rsp0_result_d = '0;
                        rsp0_err_d    = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            ST_RESP: begin
                // Response regs return to zero so the idle outputs read 0.
                if (rsp_hs_c) begin
                    rsp0_valid_d  = 1'b0;
                    rsp0_result_d = '0;
                    rsp0_err_d    = 1'b0;
                    rsp1_valid_d  = 1'b0;
                    rsp1_result_d = '0;
                    rsp1_err_d    = 1'b0;
                    last_d        = owner_q;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= ST_IDLE;
            owner_q       <= '0;
            last_q        <= REQ_ID_W'(1);
            a_q           <= '0;
            b_q           <= '0;
            timer_q       <= '0;
            start_q       <= 1'b0;
            busy_q        <= 1'b0;
            rsp0_valid_q  <= 1'b0;
            rsp0_result_q <= '0;
            rsp0_err_q    <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_result_q <= '0;
            rsp1_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            a_q           <= a_d;
            b_q           <= b_d;
            timer_q       <= timer_d;
            start_q       <= start_d;
            busy_q        <= busy_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_result_q <= rsp0_result_d;
            rsp0_err_q    <= rsp0_err_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_result_q <= rsp1_result_d;
            rsp1_err_q    <= rsp1_err_d;
        end
    end

    assign mul_start_o   = start_q;
    assign mul_a_o       = a_q;
    assign mul_b_o       = b_q;
    assign busy_o        = busy_q;
    assign rsp0_valid_o  = rsp0_valid_q;
    assign rsp0_result_o = rsp0_result_q;
    assign rsp0_err_o    = rsp0_err_q;
    assign rsp1_valid_o  = rsp1_valid_q;
    assign rsp1_result_o = rsp1_result_q;
    assign rsp1_err_o    = rsp1_err_q;

endmodule
